// File: rtl/traffic_monitor.sv
// traffic_monitor: closed-loop safety checker on the EW/NS light codes.
// Latches the first fault and holds emergency_req for all-way flashing red.
module traffic_monitor #(
   parameter int MAX_DWELL      = 64,
   parameter int MIN_YELLOW     = 2,
   parameter int RECOVER_CYCLES = 4,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] ew_light,
   input  logic [3:0] ns_light,
   input  logic       clear,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       fault_side,
   output logic       emergency_req,
   output logic       armed
);

   localparam logic [3:0] LR = 4'b0001;
   localparam logic [3:0] LY = 4'b0010;
   localparam logic [3:0] LG = 4'b0100;
   localparam logic [3:0] LF = 4'b1000;

   localparam int RC_W =
      (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] DWELL_LIM = CNT_W'(MAX_DWELL);
   localparam logic [CNT_W-1:0] YEL_MIN = CNT_W'(MIN_YELLOW);
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYCLES - 1);

   typedef enum logic [1:0] {
      ARMING,
      MONITOR,
      FAULT,
      RECOVER
   } state_t;

   typedef struct packed {
      logic enc;
      logic trans;
      logic stuck;
      logic shorty;
   } side_viol_t;

   state_t           state;
   state_t           state_d;
   logic [3:0]       prev_ew;
   logic [3:0]       prev_ns;
   logic [CNT_W-1:0] cnt_ew;
   logic [CNT_W-1:0] cnt_ns;
   logic [RC_W-1:0]  rc;
   logic [2:0]       code_q;
   logic             side_q;

   side_viol_t       v_ew;
   side_viol_t       v_ns;
   logic             conflict;
   logic             both_legal;
   logic             viol;
   logic [2:0]       code_d;
   logic             side_d;

   function automatic logic is_legal(input logic [3:0] c);
      return (c == LR) || (c == LY) || (c == LG) || (c == LF);
   endfunction

   function automatic logic is_go(input logic [3:0] c);
      return (c == LG) || (c == LY);
   endfunction

   function automatic side_viol_t check_side(
      input logic [3:0]       cur,
      input logic [3:0]       prv,
      input logic [CNT_W-1:0] cnt
   );
      side_viol_t v;
      v.enc    = !is_legal(cur);
      v.trans  = ((prv == LG) && (cur == LR)) ||
                 ((prv == LR) && (cur == LY)) ||
                 ((prv == LY) && (cur == LG));
      // prev is always legal here, so a hold implies a legal code
      v.stuck  = (cur == prv) && (cur != LF) &&
                 (cnt >= DWELL_LIM);
      v.shorty = (prv == LY) && (cur != LY) &&
                 (cnt < YEL_MIN);
      return v;
   endfunction

   function automatic logic [CNT_W-1:0] dwell_next(
      input logic [3:0]       cur,
      input logic [3:0]       prv,
      input logic [CNT_W-1:0] cnt
   );
      if (cur != prv)
         return CNT_ONE;
      else if (cnt == CNT_MAX)
         return cnt;
      else
         return cnt + CNT_ONE;
   endfunction

   assign v_ew       = check_side(ew_light, prev_ew, cnt_ew);
   assign v_ns       = check_side(ns_light, prev_ns, cnt_ns);
   assign conflict   = is_go(ew_light) && is_go(ns_light);
   assign both_legal = is_legal(ew_light) && is_legal(ns_light);

   // lowest code first, EW ahead of NS within a code
   always_comb begin
      code_d = 3'd0;
      side_d = 1'b0;
      if (v_ew.enc) begin
         code_d = 3'd1;
      end else if (v_ns.enc) begin
         code_d = 3'd1;
         side_d = 1'b1;
      end else if (conflict) begin
         code_d = 3'd2;
      end else if (v_ew.trans) begin
         code_d = 3'd3;
      end else if (v_ns.trans) begin
         code_d = 3'd3;
         side_d = 1'b1;
      end else if (v_ew.stuck) begin
         code_d = 3'd4;
      end else if (v_ns.stuck) begin
         code_d = 3'd4;
         side_d = 1'b1;
      end else if (v_ew.shorty) begin
         code_d = 3'd5;
      end else if (v_ns.shorty) begin
         code_d = 3'd5;
         side_d = 1'b1;
      end
   end

   assign viol = (code_d != 3'd0);

   always_comb begin
      state_d = state;
      unique case (state)
         ARMING:  if (both_legal) state_d = MONITOR;
         MONITOR: if (viol) state_d = FAULT;
         FAULT:   if (clear) state_d = RECOVER;
         RECOVER: if (rc == '0) state_d = ARMING;
         default: state_d = ARMING;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ARMING;
      else
         state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ew <= LR;
         prev_ns <= LR;
         cnt_ew  <= '0;
         cnt_ns  <= '0;
         rc      <= '0;
         code_q  <= 3'd0;
         side_q  <= 1'b0;
      end else begin
         unique case (state)
            ARMING: begin
               prev_ew <= ew_light;
               prev_ns <= ns_light;
               if (both_legal) begin
                  cnt_ew <= CNT_ONE;
                  cnt_ns <= CNT_ONE;
               end
            end
            MONITOR: begin
               prev_ew <= ew_light;
               prev_ns <= ns_light;
               cnt_ew  <= dwell_next(ew_light, prev_ew, cnt_ew);
               cnt_ns  <= dwell_next(ns_light, prev_ns, cnt_ns);
               if (viol) begin
                  code_q <= code_d;
                  side_q <= side_d;
               end
            end
            FAULT: begin
               if (clear) begin
                  code_q <= 3'd0;
                  side_q <= 1'b0;
                  rc     <= RC_LOAD;
               end
            end
            RECOVER: begin
               if (rc != '0) rc <= rc - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign fault         = (state == FAULT);
   assign emergency_req = (state == FAULT) || (state == RECOVER);
   assign armed         = (state == MONITOR);
   assign fault_code    = code_q;
   assign fault_side    = side_q;

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Safety monitor on the two approach-light outputs: samples the 4-bit EW and NS light codes every clock and checks encoding, cross-approach conflicts, phase-sequence legality and dwell limits. On a violation it latches a sticky fault with a code and drives `emergency_req`, which feeds the `emergency` input of both light controllers to force all-way flashing red. It sits beside the NS/EW controllers and closes the loop on their outputs.

## Interface
- `MAX_DWELL`, 64: max consecutive identical samples of green, yellow or red before a stuck fault.
- `MIN_YELLOW`, 2: min consecutive yellow samples before leaving yellow.
- `RECOVER_CYCLES`, 4: cycles `emergency_req` stays high after `clear`.
- `CNT_W`, 8: dwell counter width; must exceed clog2(`MAX_DWELL`+1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ew_light` in 4: EW controller output code.
- `ns_light` in 4: NS controller output code.
- `clear` in 1: one-cycle fault acknowledge.
- `fault` out 1: sticky fault flag.
- `fault_code` out 3: first-detected cause, 0 = none.
- `fault_side` out 1: 0 = EW, 1 = NS. Forced to 0 for conflict.
- `emergency_req` out 1: drives `emergency` of both light controllers.
- `armed` out 1: high in MONITOR.

## Operation
- Light encoding, one-hot:
  - 4'b0001 red (R)
  - 4'b0010 yellow (Y)
  - 4'b0100 green (G)
  - 4'b1000 flashing red (F)
  - Any other value, including 0, is illegal.
- States:
  - ARMING (reset state): loads prev_ew/prev_ns each cycle; all checks off. When both inputs are legal in the same sample, go to MONITOR.
  - MONITOR: every cycle, evaluate checks on the current inputs against prev registers and dwell counters, then update prev. Any violation goes to FAULT.
  - FAULT: `fault`=1 and `emergency_req`=1; checks frozen. `clear` goes to RECOVER.
  - RECOVER: `fault`=0, `fault_code`=0 and `emergency_req`=1 for `RECOVER_CYCLES` cycles, then ARMING. Violations are ignored. `clear` is ignored outside FAULT.
- Fault codes, priority lowest wins; EW beats NS within a code:
  - 1 illegal encoding
  - 2 conflict: both sides in {G,Y}
  - 3 illegal transition: G->R, R->Y, Y->G
  - 4 stuck: (`MAX_DWELL`+1)th consecutive identical sample of R, Y or G
  - 5 short yellow: leaving Y with yellow dwell < `MIN_YELLOW`
- Legal transitions: R->G, G->Y, Y->R, any->F, F->any legal code. Hold = same code.
- Dwell counters, one per side:
  - Load 1 on any code change and on entry to MONITOR.
  - Otherwise increment, saturating at 2^`CNT_W`-1.
  - F is exempt from the stuck check.
- `fault_code` and `fault_side` capture only the first violation; they hold until `clear`.

## Timing
- Reset value: every output 0, state ARMING, counters 0, prev 4'b0001.
- Detection latency: a violating sample present before edge n gives `fault`/`emergency_req` high after edge n.
- ARMING->MONITOR: `armed` rises after the edge that sampled both inputs legal. The first checked sample is the next one.
- `clear` sampled in FAULT gives `fault` low after that edge. `emergency_req` falls exactly `RECOVER_CYCLES` edges later; `armed` stays low.
- `clear` coinciding with a new violation in FAULT: clear wins and the violation is ignored.
- Async reset mid-operation: outputs drop immediately and the block returns to ARMING.

## Test plan
- Reset, EW=R/NS=G -> G->Y (Y held 2)->R, NS to R, EW to G. Expect `armed`=1, `fault`=0 throughout, and the dwell counter reloads to 1 on each change.
- In MONITOR, EW=G, NS=Y in the same sample -> after that edge `fault`=1, `fault_code`=2, `fault_side`=0, `emergency_req`=1.
- NS G->R directly -> `fault_code`=3, `fault_side`=1. Then pulse `clear`: `fault` falls next edge, `emergency_req` falls 4 edges later, and `armed` returns one sample after both inputs are legal.
- EW held G for 65 samples -> fault on the 65th (`fault_code`=4). Held F for 200 samples -> no fault.
- EW Y for 1 sample then R, with simultaneous NS=4'b0011 -> `fault_code`=1, `fault_side`=1 (priority over code 5).
- Assert `rst_n`=0 while in FAULT -> all outputs 0 with no clock edge; the block re-arms after release.
